// File: rtl/bascomp_pkg.sv
// Shared types and constants for the basic-computer RAM (bascomp_ram and its core).
package bascomp_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 12;

  localparam int ERR_COLL  = 0;
  localparam int ERR_RANGE = 1;
  localparam int ERR_BUSY  = 2;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_t;

endpackage

// File: rtl/bascomp_ram_core.sv
// Plain single-port clocked array, no reset, so synthesis maps it onto block RAM.
module bascomp_ram_core #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    if (re) dout <= mem[addr];
  end

endmodule

// File: rtl/bascomp_ram.sv
// Single-port RAM with post-reset clear sweep, ready/valid and sticky error flags.
// Define BASCOMP_RAM_WRITE_FIRST_EN for a write-first port (writes also update outdata).
module bascomp_ram
  import bascomp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] indata,
  output logic [DATA_W-1:0] outdata,
  output logic              rvalid,
  output logic              ready,
  output logic [2:0]        err,
  input  logic              err_clr
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_L  = (ADDR_W+1)'(DEPTH - 1);

  // outdata source: forced zero, array read port, or write-first bypass
  localparam logic [1:0] OSEL_ZERO = 2'd0;
  localparam logic [1:0] OSEL_CORE = 2'd1;
  localparam logic [1:0] OSEL_BYP  = 2'd2;

  state_t            state;
  logic [ADDR_W:0]   clr_cnt;
  logic [1:0]        osel;
  logic              in_range;
  logic              rd_p0;
  logic              wr_p0;
  logic [2:0]        err_ev;
  logic              core_we;
  logic              core_re;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_din;
  logic [DATA_W-1:0] core_dout;

  assign ready    = (state == IDLE);
  assign in_range = ({1'b0, addr} < DEPTH_L);
  assign rd_p0    = ready && read;
  assign wr_p0    = ready && write && !read;

  assign err_ev[ERR_COLL]  = ready && read && write;
  assign err_ev[ERR_RANGE] = ready && (read || write) && !in_range;
  assign err_ev[ERR_BUSY]  = !ready && (read || write);

  // The clear sweep owns the array port until the last word is written
  assign core_we   = ready ? (wr_p0 && in_range) : 1'b1;
  assign core_re   = rd_p0 && in_range;
  assign core_addr = ready ? addr : clr_cnt[ADDR_W-1:0];
  assign core_din  = ready ? indata : '0;

  bascomp_ram_core #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_core (
    .clk (clk),
    .we  (core_we),
    .re  (core_re),
    .addr(core_addr),
    .din (core_din),
    .dout(core_dout)
  );

  // ---- stage p0 -> p1: control state, valid, error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= INIT;
      clr_cnt <= '0;
      osel    <= OSEL_ZERO;
      rvalid  <= 1'b0;
      err     <= '0;
    end else begin
      rvalid <= 1'b0;
      case (state)
        INIT: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_L) state <= IDLE;
        end
        default: begin
          if (rd_p0) begin
            rvalid <= 1'b1;
            osel   <= in_range ? OSEL_CORE : OSEL_ZERO;
          end
`ifdef BASCOMP_RAM_WRITE_FIRST_EN
          else if (wr_p0) begin
            rvalid <= 1'b1;
            osel   <= OSEL_BYP;
          end
`endif
        end
      endcase
      if (err_clr) err <= '0;
      else         err <= err | err_ev;
    end
  end

`ifdef BASCOMP_RAM_WRITE_FIRST_EN
  logic [DATA_W-1:0] byp_p1;

  always_ff @(posedge clk) begin
    if (wr_p0) byp_p1 <= indata;
  end
`endif

  always_comb begin
    outdata = '0;
    case (osel)
      OSEL_CORE: outdata = core_dout;
`ifdef BASCOMP_RAM_WRITE_FIRST_EN
      OSEL_BYP:  outdata = byp_p1;
`endif
      default:   outdata = '0;
    endcase
  end

endmodule

// File: tb/tb_bascomp_ram.sv
// Directed self-checking bench for bascomp_ram (DEPTH=16 and DEPTH=10 instances).
module tb_bascomp_ram;

  logic        clk = 1'b0;
  int          ncheck = 0;
  int          npass  = 0;

  // instance A: DEPTH=16, ADDR_W=4
  logic        rst_n;
  logic [3:0]  addr;
  logic        read, write, err_clr;
  logic [15:0] indata, outdata;
  logic        rvalid, ready;
  logic [2:0]  err;

  // instance B: DEPTH=10, ADDR_W=4
  logic        b_rst_n;
  logic [3:0]  b_addr;
  logic        b_read, b_write, b_err_clr;
  logic [15:0] b_indata, b_outdata;
  logic        b_rvalid, b_ready;
  logic [2:0]  b_err;

  always #5 clk = ~clk;

  bascomp_ram #(.DATA_W(16), .ADDR_W(4), .DEPTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .addr(addr), .read(read), .write(write),
    .indata(indata), .outdata(outdata), .rvalid(rvalid), .ready(ready),
    .err(err), .err_clr(err_clr)
  );

  bascomp_ram #(.DATA_W(16), .ADDR_W(4), .DEPTH(10)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .addr(b_addr), .read(b_read), .write(b_write),
    .indata(b_indata), .outdata(b_outdata), .rvalid(b_rvalid), .ready(b_ready),
    .err(b_err), .err_clr(b_err_clr)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; addr = '0; read = 0; write = 0; indata = '0; err_clr = 0;
    cyc(); cyc();
    ncheck++;
    if (ready !== 1'b0 || outdata !== 16'h0 || rvalid !== 1'b0 || err !== 3'b000)
      $display("FAIL reset_state: ready=%b outdata=%h rvalid=%b err=%b, want 0/0000/0/000",
               ready, outdata, rvalid, err);
    else npass++;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ncheck++;
      if (ready !== 1'b0) $display("FAIL init_busy[%0d]: ready=%b, want 0", i, ready);
      else npass++;
      cyc();
    end
    ncheck++;
    if (ready !== 1'b1) $display("FAIL init_done: ready=%b, want 1", ready);
    else npass++;
    for (int a = 0; a < 16; a++) begin
      addr = 4'(a); read = 1'b1;
      cyc();
      ncheck++;
      if (outdata !== 16'h0000 || rvalid !== 1'b1)
        $display("FAIL sweep_read[%0d]: outdata=%h rvalid=%b, want 0000/1", a, outdata, rvalid);
      else npass++;
    end
    read = 1'b0;
    cyc();
    ncheck++;
    if (rvalid !== 1'b0) $display("FAIL rvalid_drop: rvalid=%b, want 0", rvalid);
    else npass++;
  endtask

  task automatic test_write_read();
    addr = 4'h5; indata = 16'hBEEF; write = 1'b1;
    cyc();
    ncheck++;
`ifdef BASCOMP_RAM_WRITE_FIRST_EN
    if (outdata !== 16'hBEEF || rvalid !== 1'b1)
      $display("FAIL write_port: outdata=%h rvalid=%b, want BEEF/1", outdata, rvalid);
`else
    if (outdata !== 16'h0000 || rvalid !== 1'b0)
      $display("FAIL write_port: outdata=%h rvalid=%b, want 0000/0", outdata, rvalid);
`endif
    else npass++;
    write = 1'b0; read = 1'b1;
    cyc();
    read = 1'b0;
    ncheck++;
    if (outdata !== 16'hBEEF || rvalid !== 1'b1 || err !== 3'b000)
      $display("FAIL raw_read: outdata=%h rvalid=%b err=%b, want BEEF/1/000", outdata, rvalid, err);
    else npass++;
  endtask

  task automatic test_back_to_back();
    write = 1'b1; addr = 4'h6; indata = 16'h1111; cyc();
    addr = 4'h7; indata = 16'h2222; cyc();
    write = 1'b0; read = 1'b1; addr = 4'h6; cyc();
    ncheck++;
    if (outdata !== 16'h1111 || rvalid !== 1'b1)
      $display("FAIL b2b_0: outdata=%h rvalid=%b, want 1111/1", outdata, rvalid);
    else npass++;
    addr = 4'h7; cyc();
    ncheck++;
    if (outdata !== 16'h2222 || rvalid !== 1'b1)
      $display("FAIL b2b_1: outdata=%h rvalid=%b, want 2222/1", outdata, rvalid);
    else npass++;
    read = 1'b0; cyc();
    ncheck++;
    if (outdata !== 16'h2222 || rvalid !== 1'b0)
      $display("FAIL idle_hold: outdata=%h rvalid=%b, want 2222/0", outdata, rvalid);
    else npass++;
  endtask

  task automatic test_collision();
    write = 1'b1; addr = 4'h3; indata = 16'hAAAA; cyc();
    read = 1'b1; indata = 16'h1234; cyc();
    ncheck++;
    if (outdata !== 16'hAAAA || rvalid !== 1'b1 || err !== 3'b001)
      $display("FAIL collision: outdata=%h rvalid=%b err=%b, want AAAA/1/001", outdata, rvalid, err);
    else npass++;
    write = 1'b0; cyc();
    ncheck++;
    if (outdata !== 16'hAAAA) $display("FAIL coll_reread: outdata=%h, want AAAA", outdata);
    else npass++;
    read = 1'b0; err_clr = 1'b1; cyc();
    err_clr = 1'b0;
    ncheck++;
    if (err !== 3'b000) $display("FAIL err_clr: err=%b, want 000", err);
    else npass++;
  endtask

  task automatic test_write_first();
    addr = 4'h6; read = 1'b1; cyc();
    read = 1'b0; write = 1'b1; addr = 4'h1; indata = 16'h0F0F; cyc();
    write = 1'b0;
    ncheck++;
`ifdef BASCOMP_RAM_WRITE_FIRST_EN
    if (outdata !== 16'h0F0F || rvalid !== 1'b1)
      $display("FAIL write_first: outdata=%h rvalid=%b, want 0F0F/1", outdata, rvalid);
`else
    if (outdata !== 16'h1111 || rvalid !== 1'b0)
      $display("FAIL no_change: outdata=%h rvalid=%b, want 1111/0", outdata, rvalid);
`endif
    else npass++;
    read = 1'b1; cyc(); read = 1'b0;
    ncheck++;
    if (outdata !== 16'h0F0F) $display("FAIL wf_reread: outdata=%h, want 0F0F", outdata);
    else npass++;
  endtask

  task automatic test_reset_abort();
    // outdata is AAAA-free but nonzero (0F0F) here; async reset must zero it at once
    rst_n = 1'b0; #1;
    ncheck++;
    if (outdata !== 16'h0 || ready !== 1'b0)
      $display("FAIL async_reset: outdata=%h ready=%b, want 0000/0", outdata, ready);
    else npass++;
    cyc(); rst_n = 1'b1;
    repeat (5) cyc();
    rst_n = 1'b0; #1;
    cyc(); rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 3) begin addr = 4'h5; read = 1'b1; end
      ncheck++;
      if (ready !== 1'b0) $display("FAIL restart_busy[%0d]: ready=%b, want 0", i, ready);
      else npass++;
      cyc();
      if (i == 3) begin
        read = 1'b0;
        ncheck++;
        if (rvalid !== 1'b0 || err !== 3'b100)
          $display("FAIL busy_req: rvalid=%b err=%b, want 0/100", rvalid, err);
        else npass++;
      end
    end
    ncheck++;
    if (ready !== 1'b1) $display("FAIL restart_done: ready=%b, want 1", ready);
    else npass++;
    addr = 4'h5; read = 1'b1; cyc(); read = 1'b0;
    ncheck++;
    if (outdata !== 16'h0000 || rvalid !== 1'b1)
      $display("FAIL cleared_word: outdata=%h rvalid=%b, want 0000/1", outdata, rvalid);
    else npass++;
  endtask

  task automatic test_range();
    b_rst_n = 1'b0; b_addr = '0; b_read = 0; b_write = 0; b_indata = '0; b_err_clr = 0;
    cyc(); b_rst_n = 1'b1;
    repeat (10) cyc();
    ncheck++;
    if (b_ready !== 1'b1) $display("FAIL b_ready: ready=%b, want 1", b_ready);
    else npass++;
    b_write = 1'b1; b_addr = 4'h9; b_indata = 16'h7777; cyc();
    b_addr = 4'hC; b_indata = 16'h5555; cyc();
    b_write = 1'b0;
    ncheck++;
    if (b_err !== 3'b010) $display("FAIL range_write: err=%b, want 010", b_err);
    else npass++;
    b_read = 1'b1; cyc();
    ncheck++;
    if (b_outdata !== 16'h0000 || b_rvalid !== 1'b1)
      $display("FAIL range_read: outdata=%h rvalid=%b, want 0000/1", b_outdata, b_rvalid);
    else npass++;
    b_addr = 4'h9; cyc(); b_read = 1'b0;
    ncheck++;
    if (b_outdata !== 16'h7777 || b_rvalid !== 1'b1)
      $display("FAIL last_word: outdata=%h rvalid=%b, want 7777/1", b_outdata, b_rvalid);
    else npass++;
    b_err_clr = 1'b1; b_read = 1'b1; b_addr = 4'hF; cyc();
    b_err_clr = 1'b0; b_read = 1'b0;
    ncheck++;
    if (b_err !== 3'b000) $display("FAIL clr_wins: err=%b, want 000", b_err);
    else npass++;
  endtask

  initial begin
    b_rst_n = 1'b0; b_addr = '0; b_read = 0; b_write = 0; b_indata = '0; b_err_clr = 0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_collision();
    test_write_first();
    test_reset_abort();
    test_range();
    $display("%0d/%0d checks passed", npass, ncheck);
    $finish;
  end

endmodule

// File: doc/bascomp_ram.md
Name: bascomp_ram

Overview:
- Parametrised single-port synchronous RAM for the basic computer datapath.
- Next generation of the fixed 16x4096 memory: configurable width and depth, hardware clear sweep after reset, ready/valid signalling, and sticky error flags.
- Sits between the bus/control unit and storage. Intended to map onto block RAM.

Parameters:
- DATA_W, 16, word width in bits.
- ADDR_W, 12, address width in bits.
- DEPTH, 4096, number of words; legal range 2..2**ADDR_W.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- addr  in  ADDR_W  word address.
- read  in  1  read request, sampled on posedge.
- write  in  1  write request, sampled on posedge.
- indata  in  DATA_W  write data.
- outdata  out  DATA_W  registered read data.
- rvalid  out  1  one-cycle pulse: outdata updated this cycle.
- ready  out  1  high when requests are accepted (state IDLE).
- err  out  3  sticky flags: [0] collision, [1] out-of-range, [2] access while not ready.
- err_clr  in  1  synchronous clear of err.

Behaviour:
- Reset (async assert, sync release): state=INIT, clr_cnt=0, outdata=0, rvalid=0, ready=0, err=0. The array is not reset directly.
- FSM states:
  - INIT: writes 0 to mem[clr_cnt] each cycle and increments clr_cnt. On clr_cnt==DEPTH-1, writes the last word and goes to IDLE. Total DEPTH cycles; ready rises the cycle after the final write.
  - IDLE: serves requests.
- Reset asserted mid-INIT or mid-access: the state aborts immediately and the sweep restarts from 0 after release.
- Requests while ready=0 are dropped, set err[2], and produce no rvalid.
- IDLE, read=1, write=0:
  - Next edge: outdata<=mem[addr], rvalid=1.
  - Latency 1 cycle. Back-to-back reads give one result per cycle.
- IDLE, read=0, write=1: mem[addr]<=indata on the edge. outdata holds; rvalid=0.
- IDLE, read=1, write=1: the read is performed (as above) and the write is dropped; err[0] set.
- IDLE, neither: outdata holds, rvalid=0.
- Out-of-range addr (addr>=DEPTH, only possible when DEPTH<2**ADDR_W):
  - Write is ignored.
  - Read returns outdata=0 with rvalid=1.
  - err[1] set.
- Read of an address written in the previous cycle returns the new data (no extra hazard).
- err flags are sticky.
  - err_clr has priority over a new error event in the same cycle (clear wins).
  - err_clr is honoured in every state.
- clr_cnt width is ADDR_W+1 so that DEPTH=2**ADDR_W causes no wrap.

Optional Feature:
- Macro: BASCOMP_RAM_WRITE_FIRST_EN.
- Defined: a write in IDLE also drives outdata<=indata on the same edge, with rvalid=1 (write-first port). An out-of-range write still does not update the array; outdata<=indata and err[1] are set.
- Undefined: a write leaves outdata unchanged and rvalid=0 (no-change port).

Decomposition:
- Shared package bascomp_pkg:
  - FSM state typedef {INIT, IDLE}.
  - Err bit index constants ERR_COLL=0, ERR_RANGE=1, ERR_BUSY=2.
  - Default DATA_W/ADDR_W constants.
- One sub-module, bascomp_ram_core: plain clocked array with write enable, address, din and registered dout, with no reset. It keeps inference clean.
- bascomp_ram holds the FSM, clear counter, range check, error logic and the mux for zero data in INIT.

Test Plan:
- Reset then idle, DEPTH=16: ready=0 for exactly 16 cycles after rst_n release, then 1. A read of every address returns 0x0000 with rvalid pulses.
- Write 0xBEEF @0x005, next cycle read @0x005: the cycle after the read, outdata=0xBEEF, rvalid=1, err=0.
- read=1 and write=1 @0x003, indata=0x1234, with mem[3]=0xAAAA:
  - outdata=0xAAAA; mem[3] remains 0xAAAA on re-read.
  - err=3'b001. err_clr then gives err=0.
- DEPTH=10, ADDR_W=4:
  - Write 0x5555 @0xC: ignored, err[1]=1.
  - Read @0xC: outdata=0, rvalid=1.
  - Read @9: returns prior data.
- Assert rst_n low at cycle 5 of INIT (DEPTH=16): outdata=0 immediately. After release, ready is delayed by a full 16 cycles. A read issued at cycle 3 after release sets err[2] and produces no rvalid.
- With BASCOMP_RAM_WRITE_FIRST_EN: write 0x0F0F @0x001 gives outdata=0x0F0F, rvalid=1 on the same edge. Without the macro: outdata is unchanged, rvalid=0.
